note_playback_ctrl: RTL and testbench

- Sequencer in front of note_shifter.
- Merges manual step buttons, an auto-play beat timer and song selection into single-cycle note_advance / note_reverse pulses and a stable song_sel.
- Enforces a settle window after reset or any song change, and a minimum gap between steps, so the block readers and registered display outputs in note_shifter always catch up before the next step.

---
 rtl/note_ctrl_pkg.sv | 18 +
 rtl/beat_timer.sv | 45 ++++
 rtl/note_playback_ctrl.sv | 171 +++++++++++++++++
 tb/tb_note_playback_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/note_ctrl_pkg.sv
// Shared encodings for the note playback sequencer and its beat timer.
package note_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_IDLE   = 2'd1,
        ST_PLAY   = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        MAN_NONE = 2'd0,
        MAN_NEXT = 2'd1,
        MAN_PREV = 2'd2
    } man_req_t;

    localparam int MIN_BEAT = 2;

endpackage

// File: rtl/beat_timer.sv
// Auto-play beat counter: counts 0..P-1 with P = max(beat_period, MIN_BEAT) sampled live.
module beat_timer
    import note_ctrl_pkg::*;
#(
    parameter int BEAT_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [BEAT_W-1:0] beat_period,
    output logic              wrap
);

    localparam logic [BEAT_W-1:0] MIN_P = BEAT_W'(MIN_BEAT);

    logic [BEAT_W-1:0] beat_cnt_reg;
    logic [BEAT_W-1:0] beat_cnt_next;
    logic [BEAT_W-1:0] last_cnt;

    always_comb begin
        last_cnt      = ((beat_period < MIN_P) ? MIN_P : beat_period) - 1'b1;
        wrap          = en && !clr && (beat_cnt_reg == last_cnt);
        beat_cnt_next = beat_cnt_reg;
        if (clr) begin
            beat_cnt_next = '0;
        end else if (en) begin
            // A count above the last value means the period just shrank: restart without a tick.
            if (beat_cnt_reg >= last_cnt) begin
                beat_cnt_next = '0;
            end else begin
                beat_cnt_next = beat_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            beat_cnt_reg <= '0;
        end else begin
            beat_cnt_reg <= beat_cnt_next;
        end
    end

endmodule

// File: rtl/note_playback_ctrl.sv
// Sequencer merging step buttons, auto-play beats and song selection into
// spaced single-cycle advance/reverse pulses for note_shifter.
module note_playback_ctrl
    import note_ctrl_pkg::*;
#(
    parameter int BEAT_W        = 24,
    parameter int SETTLE_CYCLES = 4,
    parameter int GAP_CYCLES    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play_toggle,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic [1:0]        song_sel_req,
    input  logic [BEAT_W-1:0] beat_period,
    input  logic              at_song_end,
    input  logic              at_song_start,
    output logic              note_advance,
    output logic              note_reverse,
    output logic [1:0]        song_sel,
    output logic              playing,
    output logic              busy,
    output logic              beat_tick,
    output logic              song_done
);

    // Pulses land GAP_CYCLES apart, but never on adjacent cycles.
    localparam int GAP_LOAD_I = ((GAP_CYCLES < 2) ? 2 : GAP_CYCLES) - 1;
    localparam int GAP_W      = $clog2(GAP_LOAD_I + 1);
    localparam int SETTLE_W   = $clog2(SETTLE_CYCLES + 1);
    localparam logic [GAP_W-1:0]    GAP_LOAD    = GAP_W'(GAP_LOAD_I);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    ctrl_state_t         state_reg, state_next;
    man_req_t            man_reg, man_next, man_eff;
    logic [SETTLE_W-1:0] settle_cnt_reg, settle_cnt_next;
    logic [GAP_W-1:0]    gap_cnt_reg, gap_cnt_next;
    logic                auto_reg, auto_next, auto_eff;
    logic [1:0]          song_sel_reg, song_sel_next;
    logic                advance_reg, advance_next;
    logic                reverse_reg, reverse_next;
    logic                tick_reg, tick_next;
    logic                done_reg, done_next;

    logic song_change, active, play_start, play_stop;
    logic timer_en, timer_clr, wrap, can_issue;

    beat_timer #(
        .BEAT_W(BEAT_W)
    ) u_beat_timer (
        .clk         (clk),
        .rst         (rst),
        .en          (timer_en),
        .clr         (timer_clr),
        .beat_period (beat_period),
        .wrap        (wrap)
    );

    always_comb begin
        song_change = (song_sel_req != song_sel_reg);
        active      = (state_reg != ST_SETTLE);
        play_start  = (state_reg == ST_IDLE) && play_toggle && !at_song_end;
        play_stop   = (state_reg == ST_PLAY) && play_toggle;
        timer_en    = (state_reg == ST_PLAY);
        timer_clr   = song_change || play_start || play_stop;
        can_issue   = active && (gap_cnt_reg == '0) && !song_change;

        // Same-cycle requests are eligible immediately; simultaneous buttons cancel out.
        man_eff = man_reg;
        if (active && (btn_next ^ btn_prev)) begin
            man_eff = btn_next ? MAN_NEXT : MAN_PREV;
        end
        auto_eff = (auto_reg || wrap) && !play_stop;

        state_next      = state_reg;
        settle_cnt_next = settle_cnt_reg;
        gap_cnt_next    = (gap_cnt_reg != '0) ? gap_cnt_reg - 1'b1 : gap_cnt_reg;
        man_next        = man_eff;
        auto_next       = auto_eff;
        song_sel_next   = song_sel_reg;
        advance_next    = 1'b0;
        reverse_next    = 1'b0;
        tick_next       = wrap;
        done_next       = 1'b0;

        case (state_reg)
            ST_SETTLE: begin
                if (settle_cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    settle_cnt_next = settle_cnt_reg - 1'b1;
                end
            end
            ST_IDLE: begin
                if (play_start) begin
                    state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (play_stop) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_SETTLE;
        endcase

        if (can_issue) begin
            if (man_eff != MAN_NONE) begin
                man_next     = MAN_NONE;
                advance_next = (man_eff == MAN_NEXT) && !at_song_end;
                reverse_next = (man_eff == MAN_PREV) && !at_song_start;
            end else if (auto_eff) begin
                auto_next = 1'b0;
                if (at_song_end) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else begin
                    advance_next = 1'b1;
                end
            end
        end
        if (advance_next || reverse_next) begin
            gap_cnt_next = GAP_LOAD;
        end

        if (song_change) begin
            song_sel_next   = song_sel_req;
            state_next      = ST_SETTLE;
            settle_cnt_next = SETTLE_LOAD;
            man_next        = MAN_NONE;
            auto_next       = 1'b0;
            tick_next       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_SETTLE;
            settle_cnt_reg <= SETTLE_LOAD;
            gap_cnt_reg    <= '0;
            man_reg        <= MAN_NONE;
            auto_reg       <= 1'b0;
            song_sel_reg   <= 2'd0;
            advance_reg    <= 1'b0;
            reverse_reg    <= 1'b0;
            tick_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            settle_cnt_reg <= settle_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            man_reg        <= man_next;
            auto_reg       <= auto_next;
            song_sel_reg   <= song_sel_next;
            advance_reg    <= advance_next;
            reverse_reg    <= reverse_next;
            tick_reg       <= tick_next;
            done_reg       <= done_next;
        end
    end

    assign note_advance = advance_reg;
    assign note_reverse = reverse_reg;
    assign song_sel     = song_sel_reg;
    assign playing      = (state_reg == ST_PLAY);
    assign busy         = (state_reg == ST_SETTLE) || (gap_cnt_reg != '0);
    assign beat_tick    = tick_reg;
    assign song_done    = done_reg;

endmodule

// File: tb/tb_note_playback_ctrl.sv
// Directed and randomized bench for note_playback_ctrl against a timestamp-based reference model.
module tb_note_playback_ctrl;

    localparam int BEAT_W        = 24;
    localparam int SETTLE_CYCLES = 4;
    localparam int GAP_CYCLES    = 2;
    localparam int SPACING       = (GAP_CYCLES < 2) ? 2 : GAP_CYCLES;
    localparam int M_SETTLE = 0, M_IDLE = 1, M_PLAY = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              play_toggle, btn_next, btn_prev;
    logic [1:0]        song_sel_req;
    logic [BEAT_W-1:0] beat_period;
    logic              at_song_end, at_song_start;
    logic              note_advance, note_reverse, playing, busy, beat_tick, song_done;
    logic [1:0]        song_sel;

    note_playback_ctrl #(
        .BEAT_W        (BEAT_W),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .GAP_CYCLES    (GAP_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .play_toggle   (play_toggle),
        .btn_next      (btn_next),
        .btn_prev      (btn_prev),
        .song_sel_req  (song_sel_req),
        .beat_period   (beat_period),
        .at_song_end   (at_song_end),
        .at_song_start (at_song_start),
        .note_advance  (note_advance),
        .note_reverse  (note_reverse),
        .song_sel      (song_sel),
        .playing       (playing),
        .busy          (busy),
        .beat_tick     (beat_tick),
        .song_done     (song_done)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: mode, settle countdown, timestamp of the last issued step, beat phase.
    int         m_mode, m_settle_left, m_cyc, m_last_issue, m_phase, m_man;
    bit         m_auto;
    logic [1:0] m_song;
    logic       e_adv, e_rev, e_tick, e_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, m_cyc);
        end
    endtask

    task automatic model_step();
        int  p;
        bit  wrap, stop, start;
        m_cyc++;
        e_adv = 0; e_rev = 0; e_tick = 0; e_done = 0;
        if (!rst) begin
            m_mode = M_SETTLE; m_settle_left = SETTLE_CYCLES; m_last_issue = -1000;
            m_phase = 0; m_man = 0; m_auto = 0; m_song = 2'd0;
        end else if (song_sel_req != m_song) begin
            m_song = song_sel_req; m_mode = M_SETTLE; m_settle_left = SETTLE_CYCLES;
            m_phase = 0; m_man = 0; m_auto = 0;
        end else if (m_mode == M_SETTLE) begin
            m_settle_left--;
            if (m_settle_left == 0) m_mode = M_IDLE;
        end else begin
            if (btn_next != btn_prev) m_man = btn_next ? 1 : 2;
            stop  = (m_mode == M_PLAY) && play_toggle;
            start = (m_mode == M_IDLE) && play_toggle && !at_song_end;
            wrap  = 0;
            if (m_mode == M_PLAY && !stop) begin
                p = (int'(beat_period) < 2) ? 2 : int'(beat_period);
                if (m_phase == p - 1) begin wrap = 1; m_phase = 0; end
                else if (m_phase >= p) m_phase = 0;
                else m_phase++;
            end
            if (stop) begin m_mode = M_IDLE; m_phase = 0; m_auto = 0; end
            if (start) begin m_mode = M_PLAY; m_phase = 0; end
            if (wrap) m_auto = 1;
            e_tick = wrap;
            if (m_cyc - m_last_issue >= SPACING) begin
                if (m_man != 0) begin
                    e_adv = (m_man == 1) && !at_song_end;
                    e_rev = (m_man == 2) && !at_song_start;
                    m_man = 0;
                end else if (m_auto) begin
                    m_auto = 0;
                    if (at_song_end) begin m_mode = M_IDLE; e_done = 1; end
                    else e_adv = 1;
                end
                if (e_adv || e_rev) m_last_issue = m_cyc;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        check("note_advance", note_advance, e_adv);
        check("note_reverse", note_reverse, e_rev);
        check("beat_tick", beat_tick, e_tick);
        check("song_done", song_done, e_done);
        check("song_sel", song_sel, m_song);
        check("playing", playing, m_mode == M_PLAY);
        check("busy", busy, (m_mode == M_SETTLE) || (m_cyc + 1 - m_last_issue < SPACING));
        check("one_hot_step", note_advance & note_reverse, 1'b0);
        if (e_adv || e_rev || e_done)
            $display("cycle %0d: advance=%0b reverse=%0b done=%0b song=%0d playing=%0b",
                     m_cyc, note_advance, note_reverse, song_done, song_sel, playing);
    endtask

    task automatic pulse(input logic tog, input logic nx, input logic pv);
        play_toggle = tog; btn_next = nx; btn_prev = pv;
        step();
        play_toggle = 0; btn_next = 0; btn_prev = 0;
    endtask

    initial begin
        int dones;
        m_cyc = 0;
        rst = 0; play_toggle = 0; btn_next = 0; btn_prev = 0; song_sel_req = 2'd0;
        beat_period = BEAT_W'(5); at_song_end = 0; at_song_start = 0;

        // Reset and settle window
        step(); step();
        check("reset_busy", busy, 1'b1);
        check("reset_playing", playing, 1'b0);
        rst = 1;
        step(); step(); step();
        check("settle_busy", busy, 1'b1);
        step();
        check("settle_exit", busy, 1'b0);

        // Manual stepping with gap holdoff
        pulse(0, 1, 0);
        check("adv_t1", note_advance, 1'b1);
        pulse(0, 1, 0);
        check("adv_held", note_advance, 1'b0);
        pulse(0, 0, 0);
        check("adv_t3", note_advance, 1'b1);
        step(); step();

        // Cancelling buttons and blocked reverse
        pulse(0, 1, 1);
        check("both_btn", note_advance | note_reverse, 1'b0);
        at_song_start = 1;
        pulse(0, 0, 1);
        check("prev_at_start", note_reverse, 1'b0);
        at_song_start = 0;
        pulse(0, 0, 1);
        check("prev_ok", note_reverse, 1'b1);
        step(); step();

        // Auto-play at period 5, then clamped period
        pulse(1, 0, 0);
        check("play_on", playing, 1'b1);
        for (int i = 0; i < 20; i++) step();
        beat_period = BEAT_W'(1);
        for (int i = 0; i < 8; i++) step();
        beat_period = BEAT_W'(5);

        // Stop at song end on a beat wrap
        at_song_end = 1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (song_done) dones++;
        end
        check("song_done_count", dones, 1);
        check("stopped", playing, 1'b0);
        at_song_end = 0;

        // Song change mid-play with a pending step
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        pulse(0, 1, 0);
        song_sel_req = 2'd2;
        step();
        check("song_switch", song_sel, 2'd2);
        check("switch_stops", playing, 1'b0);
        for (int i = 0; i < 6; i++) step();

        // Reset in the middle of a gap
        pulse(0, 1, 0);
        rst = 0;
        step();
        check("rst_mid_sel", song_sel, 2'd0);
        check("rst_mid_busy", busy, 1'b1);
        rst = 1;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            play_toggle = ($urandom_range(0, 24) == 0);
            btn_next    = ($urandom_range(0, 5) == 0);
            btn_prev    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) song_sel_req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) beat_period = BEAT_W'($urandom_range(0, 9));
            if ($urandom_range(0, 14) == 0) at_song_end = ~at_song_end;
            if ($urandom_range(0, 14) == 0) at_song_start = ~at_song_start;
            rst = ($urandom_range(0, 599) != 0);
            step();
        end
        rst = 1;
        play_toggle = 0; btn_next = 0; btn_prev = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
